// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: shared constants and types for the full-speed USB receiver.
//  - rx_packet codes reported to the protocol controller
//  - PID bytes (as received, LSB first) and the SYNC pattern
//  - line levels as {dp,dm}, bit-timing constants, FSM state enum
//  - pid_decode(): maps a PID byte to its rx_packet code (RX_NONE if unsupported)
package usb_rx_pkg;

  // rx_packet codes
  localparam logic [2:0] RX_NONE  = 3'd0;
  localparam logic [2:0] RX_OUT   = 3'd1;
  localparam logic [2:0] RX_IN    = 3'd2;
  localparam logic [2:0] RX_DATA0 = 3'd3;
  localparam logic [2:0] RX_DATA1 = 3'd4;
  localparam logic [2:0] RX_ACK   = 3'd5;
  localparam logic [2:0] RX_NAK   = 3'd6;
  localparam logic [2:0] RX_STALL = 3'd7;

  // PID bytes
  localparam logic [7:0] PID_OUT   = 8'hE1;
  localparam logic [7:0] PID_IN    = 8'h69;
  localparam logic [7:0] PID_DATA0 = 8'hC3;
  localparam logic [7:0] PID_DATA1 = 8'h4B;
  localparam logic [7:0] PID_ACK   = 8'hD2;
  localparam logic [7:0] PID_NAK   = 8'h5A;
  localparam logic [7:0] PID_STALL = 8'h1E;

  localparam logic [7:0] SYNC_BYTE  = 8'h80;
  localparam int         FIFO_DEPTH = 64;

  // Line levels, {dp,dm}
  localparam logic [1:0] LINE_SE0 = 2'b00;
  localparam logic [1:0] LINE_K   = 2'b01;
  localparam logic [1:0] LINE_J   = 2'b10;

  // Bit timing at 100 MHz / 12 Mb/s: bit lengths cycle 8,8,9 clk (25 clk per 3 bits).
  // Counter values are "cycles to wait minus one" since the sample fires at zero.
  localparam logic [3:0] CLK_MID_BIT   = 4'd4;
  localparam logic [3:0] CLK_BIT_SHORT = 4'd8;
  localparam logic [3:0] CLK_BIT_LONG  = 4'd9;

  // Consecutive ones after which the next bit is a stuffed bit
  localparam logic [2:0] STUFF_RUN = 3'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_PID,
    ST_DATA,
    ST_TOKEN,
    ST_EOP_WAIT,
    ST_ERROR
  } rx_state_e;

  function automatic logic [2:0] pid_decode(input logic [7:0] pid);
    logic [2:0] code;
    code = RX_NONE;
    case (pid)
      PID_OUT:   code = RX_OUT;
      PID_IN:    code = RX_IN;
      PID_DATA0: code = RX_DATA0;
      PID_DATA1: code = RX_DATA1;
      PID_ACK:   code = RX_ACK;
      PID_NAK:   code = RX_NAK;
      PID_STALL: code = RX_STALL;
      default:   code = RX_NONE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/usb_rx_unit_bitrecov.sv
// usb_rx_unit_bitrecov: bit recovery front end.
//  Synchronizes dp/dm, re-times the bit clock on every line edge, samples at
//  mid-bit, NRZI-decodes and removes stuffed bits.
// Ports:
//  clk, n_rst     clock, async active-low reset
//  dp_in, dm_in   raw (asynchronous) USB lines
//  unstuff_clr    hold the ones-run counter at zero (receiver not in a packet)
//  bit_valid      1-clk strobe: rx_bit is a decoded, unstuffed data bit
//  rx_bit         decoded bit value
//  se0            1-clk strobe: the current sample is SE0
//  stuff_err      1-clk strobe: a stuffed-bit slot carried a 1
module usb_rx_unit_bitrecov
  import usb_rx_pkg::*;
(
  input  logic clk,
  input  logic n_rst,
  input  logic dp_in,
  input  logic dm_in,
  input  logic unstuff_clr,
  output logic bit_valid,
  output logic rx_bit,
  output logic se0,
  output logic stuff_err
);

  logic [1:0] meta_q, sync_q, last_q;   // {dp,dm}: two sync flops plus edge history
  logic [1:0] prev_q, prev_d;           // level at the previous bit sample
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] phase_q, phase_d;
  logic [2:0] ones_q, ones_d;
  logic [2:0] ones_cur;
  logic       line_edge, smp, nrzi;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta_q  <= LINE_J;
      sync_q  <= LINE_J;
      last_q  <= LINE_J;
      prev_q  <= LINE_J;
      cnt_q   <= CLK_BIT_SHORT - 4'd1;
      phase_q <= '0;
      ones_q  <= '0;
    end else begin
      meta_q  <= {dp_in, dm_in};
      sync_q  <= meta_q;
      last_q  <= sync_q;
      prev_q  <= prev_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      ones_q  <= ones_d;
    end
  end

  assign line_edge = (sync_q != last_q);

  // Bit timer: an edge restarts it half a bit out; without edges it free-runs
  // with the 8,8,9 pattern so long runs stay centred.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    smp     = 1'b0;
    if (line_edge) begin
      cnt_d   = CLK_MID_BIT - 4'd1;
      phase_d = '0;
    end else if (cnt_q == '0) begin
      smp     = 1'b1;
      cnt_d   = ((phase_q == 2'd2) ? CLK_BIT_LONG : CLK_BIT_SHORT) - 4'd1;
      phase_d = (phase_q == 2'd2) ? 2'd0 : phase_q + 2'd1;
    end else begin
      cnt_d = cnt_q - 4'd1;
    end
  end

  // NRZI decode and unstuff. SE0 resets the NRZI reference to J (the idle
  // level that follows an EOP), so a K after idle or EOP always decodes as 0.
  always_comb begin
    bit_valid = 1'b0;
    rx_bit    = 1'b0;
    se0       = 1'b0;
    stuff_err = 1'b0;
    prev_d    = prev_q;
    ones_cur  = unstuff_clr ? 3'd0 : ones_q;
    ones_d    = ones_cur;
    nrzi      = (sync_q == prev_q);
    if (smp) begin
      if (sync_q == LINE_SE0) begin
        se0    = 1'b1;
        prev_d = LINE_J;
        ones_d = '0;
      end else begin
        prev_d = sync_q;
        if (ones_cur == STUFF_RUN) begin
          // stuffed slot: dropped; it must have been a transition
          ones_d    = '0;
          stuff_err = nrzi;
        end else begin
          bit_valid = 1'b1;
          rx_bit    = nrzi;
          ones_d    = nrzi ? ones_cur + 3'd1 : 3'd0;
        end
      end
    end
  end

endmodule

// File: rtl/usb_rx_unit.sv
// usb_rx_unit: full-speed USB packet receiver.
//  Bit recovery in usb_rx_unit_bitrecov; this level assembles bytes and runs
//  the packet FSM (SYNC check, PID decode, payload streaming, EOP handling).
// Ports:
//  clk, n_rst            100 MHz clock, async active-low reset
//  dp_in, dm_in          USB lines (asynchronous)
//  buffer_occupancy      RX FIFO fill level, 0..64
//  flush                 1-clk pulse: clear RX FIFO (start of a DATA packet)
//  rx_data_ready         DATA packet received without error
//  rx_transfer_active    packet in progress
//  rx_error              packet aborted/errored (sticky until next SYNC)
//  rx_packet             last valid PID code
//  rx_packet_data        payload byte, valid with rx_store_packet_data
//  rx_store_packet_data  1-clk pulse: push rx_packet_data into FIFO
module usb_rx_unit
  import usb_rx_pkg::*;
(
  input  logic       clk,
  input  logic       n_rst,
  input  logic       dp_in,
  input  logic       dm_in,
  input  logic [6:0] buffer_occupancy,
  output logic       flush,
  output logic       rx_data_ready,
  output logic       rx_transfer_active,
  output logic       rx_error,
  output logic [2:0] rx_packet,
  output logic [7:0] rx_packet_data,
  output logic       rx_store_packet_data
);

  logic bit_valid, rx_bit, se0, stuff_err, unstuff_clr;

  rx_state_e  state_q, state_d;
  logic [6:0] shreg_q, shreg_d;         // bits 1..7 of the byte in progress
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       se0_run_q, se0_run_d;     // previous sample was SE0
  logic       got_byte_q, got_byte_d;
  logic [2:0] packet_q, packet_d;
  logic [7:0] data_q, data_d;
  logic       store_q, store_d;
  logic       flush_q, flush_d;
  logic       ready_q, ready_d;
  logic       active_q, active_d;
  logic       error_q, error_d;

  logic       start, receiving, shift_en, byte_done, eop, pid_ok, fifo_full;
  logic [7:0] byte_now;
  logic [2:0] pid_code;

  usb_rx_unit_bitrecov u_bitrecov (
    .clk         (clk),
    .n_rst       (n_rst),
    .dp_in       (dp_in),
    .dm_in       (dm_in),
    .unstuff_clr (unstuff_clr),
    .bit_valid   (bit_valid),
    .rx_bit      (rx_bit),
    .se0         (se0),
    .stuff_err   (stuff_err)
  );

  // Outside a packet the line idles at J, which decodes as a run of ones;
  // that run must not make the first SYNC bit look like a stuffed bit.
  assign unstuff_clr = (state_q == ST_IDLE) || (state_q == ST_EOP_WAIT) ||
                       (state_q == ST_ERROR);

  // In IDLE the NRZI reference is J, so a decoded 0 means the line went to K.
  assign start     = (state_q == ST_IDLE) && bit_valid && !rx_bit;
  assign receiving = (state_q == ST_SYNC) || (state_q == ST_PID) ||
                     (state_q == ST_DATA) || (state_q == ST_TOKEN);
  assign shift_en  = bit_valid && (receiving || start);
  assign byte_now  = {rx_bit, shreg_q};
  assign byte_done = shift_en && (bit_cnt_q == 3'd7);
  assign eop       = se0 && se0_run_q;
  assign pid_ok    = (byte_now[3:0] == ~byte_now[7:4]);
  assign pid_code  = pid_decode(byte_now);
  assign fifo_full = (buffer_occupancy >= 7'(FIFO_DEPTH));

  // ---- state register ----
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---- next state ----
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_SYNC;
      ST_SYNC: begin
        if (se0 || stuff_err) state_d = ST_ERROR;
        else if (byte_done)   state_d = (byte_now == SYNC_BYTE) ? ST_PID : ST_ERROR;
      end
      ST_PID: begin
        if (se0 || stuff_err) state_d = ST_ERROR;
        else if (byte_done) begin
          if (!pid_ok)                                          state_d = ST_ERROR;
          else if (pid_code == RX_DATA0 || pid_code == RX_DATA1) state_d = ST_DATA;
          else if (pid_code != RX_NONE)                         state_d = ST_TOKEN;
          else                                                  state_d = ST_ERROR;
        end
      end
      ST_DATA: begin
        if (stuff_err)                   state_d = ST_ERROR;
        else if (eop)                    state_d = ST_EOP_WAIT;
        else if (byte_done && fifo_full) state_d = ST_ERROR;
      end
      ST_TOKEN: begin
        if (stuff_err) state_d = ST_ERROR;
        else if (eop)  state_d = ST_EOP_WAIT;
      end
      ST_EOP_WAIT: if (se0 || (bit_valid && rx_bit)) state_d = ST_IDLE;
      ST_ERROR:    if (eop) state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // ---- outputs / status ----
  always_comb begin
    flush_d    = 1'b0;
    store_d    = 1'b0;
    data_d     = data_q;
    packet_d   = packet_q;
    ready_d    = ready_q;
    active_d   = active_q;
    error_d    = error_q;
    got_byte_d = got_byte_q;
    if (start) begin
      error_d    = 1'b0;
      ready_d    = 1'b0;
      active_d   = 1'b1;
      got_byte_d = 1'b0;
    end
    case (state_q)
      ST_PID: begin
        if (byte_done && pid_ok && pid_code != RX_NONE) begin
          packet_d = pid_code;
          flush_d  = (pid_code == RX_DATA0) || (pid_code == RX_DATA1);
        end
      end
      ST_DATA: begin
        if (byte_done && !fifo_full) begin
          store_d    = 1'b1;
          data_d     = byte_now;
          got_byte_d = 1'b1;
        end
        if (eop) begin
          active_d = 1'b0;
          if (bit_cnt_q != '0) error_d = 1'b1;
          else                 ready_d = got_byte_q;
        end
      end
      ST_TOKEN: begin
        if (eop) begin
          active_d = 1'b0;
          if (bit_cnt_q != '0) error_d = 1'b1;
        end
      end
      default: ;
    endcase
    if (state_d == ST_ERROR) begin
      error_d  = 1'b1;
      active_d = 1'b0;
    end
  end

  // ---- byte assembly / EOP tracking ----
  always_comb begin
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    se0_run_d = se0_run_q;
    if (shift_en) begin
      shreg_d   = byte_now[7:1];
      bit_cnt_d = bit_cnt_q + 3'd1;
    end else if (!receiving) begin
      bit_cnt_d = '0;
    end
    if (se0)                         se0_run_d = 1'b1;
    else if (bit_valid || stuff_err) se0_run_d = 1'b0;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      shreg_q    <= '0;
      bit_cnt_q  <= '0;
      se0_run_q  <= 1'b0;
      got_byte_q <= 1'b0;
      packet_q   <= RX_NONE;
      data_q     <= '0;
      store_q    <= 1'b0;
      flush_q    <= 1'b0;
      ready_q    <= 1'b0;
      active_q   <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      bit_cnt_q  <= bit_cnt_d;
      se0_run_q  <= se0_run_d;
      got_byte_q <= got_byte_d;
      packet_q   <= packet_d;
      data_q     <= data_d;
      store_q    <= store_d;
      flush_q    <= flush_d;
      ready_q    <= ready_d;
      active_q   <= active_d;
      error_q    <= error_d;
    end
  end

  assign flush                = flush_q;
  assign rx_data_ready        = ready_q;
  assign rx_transfer_active   = active_q;
  assign rx_error             = error_q;
  assign rx_packet            = packet_q;
  assign rx_packet_data       = data_q;
  assign rx_store_packet_data = store_q;

endmodule

// File: tb/tb_usb_rx_unit.sv
// tb_usb_rx_unit: directed, table-driven bench for usb_rx_unit.
//  The bench NRZI-encodes (with bit stuffing) whole packets onto dp/dm using
//  8,8,9-clock bits, records flush pulses and FIFO stores, and compares the
//  status outputs after each packet against hand-computed expectations.
module tb_usb_rx_unit;
  import usb_rx_pkg::*;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       dp_in = 1'b1;
  logic       dm_in = 1'b0;
  logic [6:0] buffer_occupancy = '0;
  logic       flush, rx_data_ready, rx_transfer_active, rx_error, rx_store_packet_data;
  logic [2:0] rx_packet;
  logic [7:0] rx_packet_data;

  always #5 clk = ~clk;

  usb_rx_unit dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .dp_in                (dp_in),
    .dm_in                (dm_in),
    .buffer_occupancy     (buffer_occupancy),
    .flush                (flush),
    .rx_data_ready        (rx_data_ready),
    .rx_transfer_active   (rx_transfer_active),
    .rx_error             (rx_error),
    .rx_packet            (rx_packet),
    .rx_packet_data       (rx_packet_data),
    .rx_store_packet_data (rx_store_packet_data)
  );

  int         total = 0;
  int         bad = 0;
  int         flush_n = 0;
  logic [7:0] got_q[$];
  logic [1:0] cur = 2'b10;   // current driven J/K level
  int         ones = 0;      // encoder ones run, for stuffing
  int         ph = 0;        // bench bit-length phase

  // FIFO-side recorder
  always @(negedge clk) begin
    if (rx_store_packet_data) got_q.push_back(rx_packet_data);
    if (flush) flush_n++;
  end

  typedef struct {
    logic [7:0] pid;
    int         npay;    // payload bytes sent: A8 then A9s
    logic [6:0] occ;
    logic [2:0] e_pkt;
    int         e_flush;
    int         e_st;    // expected stores (A8 then A9s)
    logic       e_rdy;
    logic       e_err;
    logic       e_act;   // rx_transfer_active just before EOP
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] lvl, input int n);
    for (int i = 0; i < n; i++) begin
      {dp_in, dm_in} = lvl;
      repeat ((ph == 2) ? 9 : 8) @(negedge clk);
      ph = (ph + 1) % 3;
    end
  endtask

  task automatic send_bits(input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      if (d[i]) ones++;
      else begin
        cur  = ~cur;
        ones = 0;
      end
      drive(cur, 1);
      if (ones == 6) begin
        cur  = ~cur;
        ones = 0;
        drive(cur, 1);
      end
    end
  endtask

  task automatic start_pkt();
    cur  = LINE_J;
    ones = 0;
    drive(LINE_J, 4);
    send_bits(SYNC_BYTE, 8);
  endtask

  task automatic send_eop();
    drive(LINE_SE0, 2);
    cur  = LINE_J;
    ones = 0;
    drive(LINE_J, 4);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int f0, s0;
    f0 = flush_n;
    s0 = got_q.size();
    buffer_occupancy = v.occ;
    start_pkt();
    send_bits(v.pid, 8);
    for (int i = 0; i < v.npay; i++) send_bits((i == 0) ? 8'hA8 : 8'hA9, 8);
    check($sformatf("v%0d active_before_eop", idx), int'(rx_transfer_active), int'(v.e_act));
    send_eop();
    check($sformatf("v%0d rx_packet", idx), int'(rx_packet), int'(v.e_pkt));
    check($sformatf("v%0d flush_pulses", idx), flush_n - f0, v.e_flush);
    check($sformatf("v%0d store_count", idx), got_q.size() - s0, v.e_st);
    for (int i = 0; i < v.e_st; i++)
      if (s0 + i < got_q.size())
        check($sformatf("v%0d store_byte%0d", idx, i), int'(got_q[s0 + i]),
              (i == 0) ? 32'hA8 : 32'hA9);
    check($sformatf("v%0d rx_data_ready", idx), int'(rx_data_ready), int'(v.e_rdy));
    check($sformatf("v%0d rx_error", idx), int'(rx_error), int'(v.e_err));
    check($sformatf("v%0d active_after_eop", idx), int'(rx_transfer_active), 0);
    buffer_occupancy = '0;
  endtask

  initial begin
    int f0, s0;
    //             pid    npay occ    pkt       fl st rdy   err   act
    vecs[0]  = '{8'hC3, 1, 7'd0,  RX_DATA0, 1, 1, 1'b1, 1'b0, 1'b1};
    vecs[1]  = '{8'hC3, 2, 7'd0,  RX_DATA0, 1, 2, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{8'hC3, 6, 7'd0,  RX_DATA0, 1, 6, 1'b1, 1'b0, 1'b1};
    vecs[3]  = '{8'h4B, 1, 7'd0,  RX_DATA1, 1, 1, 1'b1, 1'b0, 1'b1};
    vecs[4]  = '{8'hD2, 0, 7'd0,  RX_ACK,   0, 0, 1'b0, 1'b0, 1'b1};
    vecs[5]  = '{8'h69, 2, 7'd0,  RX_IN,    0, 0, 1'b0, 1'b0, 1'b1};
    vecs[6]  = '{8'hC3, 2, 7'd64, RX_DATA0, 1, 0, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{8'hCF, 1, 7'd0,  RX_DATA0, 0, 0, 1'b0, 1'b1, 1'b0};
    vecs[8]  = '{8'h2D, 1, 7'd0,  RX_DATA0, 0, 0, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{8'h5A, 1, 7'd0,  RX_NAK,   0, 0, 1'b0, 1'b0, 1'b1};
    vecs[10] = '{8'h1E, 0, 7'd0,  RX_STALL, 0, 0, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{8'hC3, 0, 7'd0,  RX_DATA0, 1, 0, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{8'hC3, 3, 7'd63, RX_DATA0, 1, 3, 1'b1, 1'b0, 1'b1};

    // reset state
    repeat (3) @(negedge clk);
    check("reset rx_packet", int'(rx_packet), int'(RX_NONE));
    check("reset flags", int'({flush, rx_data_ready, rx_transfer_active, rx_error,
                               rx_store_packet_data}), 0);
    n_rst = 1'b1;
    drive(LINE_J, 6);
    check("idle no activity", int'({rx_transfer_active, rx_error}), 0);

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // OUT token, then K held for 16 bits: stuffing violation
    f0 = flush_n;
    s0 = got_q.size();
    start_pkt();
    send_bits(PID_OUT, 8);
    drive(cur, 16);
    send_eop();
    check("stuff rx_packet", int'(rx_packet), int'(RX_OUT));
    check("stuff rx_error", int'(rx_error), 1);
    check("stuff active", int'(rx_transfer_active), 0);
    check("stuff no store/flush", (got_q.size() - s0) + (flush_n - f0), 0);

    // partial byte before EOP
    s0 = got_q.size();
    start_pkt();
    send_bits(PID_DATA0, 8);
    send_bits(8'hA8, 8);
    send_bits(8'h05, 3);
    send_eop();
    check("partial store_count", got_q.size() - s0, 1);
    check("partial rx_error", int'(rx_error), 1);
    check("partial rx_data_ready", int'(rx_data_ready), 0);

    // async reset in the middle of a DATA packet
    start_pkt();
    send_bits(PID_DATA0, 8);
    send_bits(8'hA8, 4);
    check("midreset active_before", int'(rx_transfer_active), 1);
    n_rst = 1'b0;
    {dp_in, dm_in} = LINE_J;
    #1;
    check("midreset rx_packet", int'(rx_packet), int'(RX_NONE));
    check("midreset flags", int'({flush, rx_data_ready, rx_transfer_active, rx_error,
                                  rx_store_packet_data}), 0);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    run_vec(vecs[1], 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
